pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage that sits directly downstream of the branch unit.
- Consumes PC_Src, selects the next PC (sequential, PC-relative branch/JAL target, or JALR target), and fetches the instruction over a request/response memory handshake.
- Holds the fetched instruction stable for the single-cycle datapath until the core signals commit.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- PC_Src  input  1  branch-unit decision: 1 = redirect to target, 0 = PC+4.
- jalr  input  1  when PC_Src=1, selects alu_result instead of PC+imm as the target.
- imm  input  XLEN  sign-extended branch/JAL offset.
- alu_result  input  XLEN  JALR target address from the ALU.
- commit  input  1  core has finished executing instr this cycle.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address; equals PC.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  XLEN  fetched instruction word.
- instr  output  XLEN  registered instruction for decode.
- instr_valid  output  1  instr is valid and is being executed.
- PC  output  XLEN  address of the current instruction.
- PC_plus4  output  XLEN  PC+4, combinational from PC, for JAL/JALR link.
- misaligned  output  1  sticky fetch-target-misaligned error.

Behaviour:
- States: BOOT, REQ, WAIT, HOLD, ERR.
- Reset (asynchronous, active-high) forces:
  - state=BOOT, PC=RESET_PC, instr=0, instr_valid=0, imem_req=0, misaligned=0.
  - Reset asserted mid-operation aborts any fetch in any state.
- BOOT: lasts exactly 1 cycle after reset deasserts, then goes to REQ. imem_req=0.
- REQ:
  - imem_req=1 and imem_addr=PC, held stable until imem_ready=1.
  - imem_ready=1 with imem_rvalid=1 in the same cycle (zero-wait memory): instr<=imem_rdata, go to HOLD.
  - imem_ready=1 with imem_rvalid=0: go to WAIT.
  - imem_rvalid=1 while imem_ready=0: ignored.
- WAIT:
  - imem_req=0.
  - On imem_rvalid=1: instr<=imem_rdata, go to HOLD. Otherwise stay in WAIT; no timeout.
- HOLD:
  - instr_valid=1; instr and PC are stable.
  - On commit=1, compute next_pc:
    - PC_Src=0: PC+4.
    - PC_Src=1, jalr=0: PC+imm.
    - PC_Src=1, jalr=1: {alu_result[XLEN-1:1],1'b0}.
  - All additions are modulo 2^XLEN; wrap-around is silent.
  - If next_pc[1:0]!=2'b00: go to ERR, set misaligned=1, leave PC unchanged.
  - Otherwise: PC<=next_pc, instr_valid<=0, go to REQ.
- Registered-output timing:
  - instr_valid rises the cycle after the accepting edge.
  - Minimum commit-to-next-instr_valid latency is 2 cycles: HOLD→REQ, then REQ→HOLD with zero-wait memory.
- Input sampling:
  - PC_Src, jalr, imm and alu_result are sampled only on the commit cycle in HOLD.
  - commit outside HOLD is ignored.
- ERR:
  - imem_req=0, instr_valid=0, misaligned=1.
  - Exited only by reset.
- imem_rvalid in BOOT, HOLD or ERR is ignored and does not disturb instr.
- Assertion: imem_addr[1:0] is always 0 whenever imem_req=1.

Test Plan:
- Reset boot with RESET_PC=0 and zero-wait memory returning 32'h0000_0013 → imem_req=1/addr=0 in the cycle after BOOT; next cycle instr=32'h13, instr_valid=1, PC=0, PC_plus4=4.
- Sequential flow: commit with PC_Src=0 three times → imem_addr sequence 0x4, 0x8, 0xC; instr_valid low for exactly 1 cycle between instructions.
- Taken branch: PC=0x10, PC_Src=1, jalr=0, imm=-8 → next fetch at 0x08. Then JALR with alu_result=0x0000_0101 → fetch at 0x100.
- Wait states: imem_ready low for 3 cycles with addr held stable, then rvalid 2 cycles after acceptance, plus a spurious rvalid during REQ → instr captured only from the WAIT response, instr_valid rises once.
- Misaligned target: PC_Src=1, jalr=0, PC=0x20, imm=6 → misaligned=1, state ERR, imem_req stays 0, PC stays 0x20; a subsequent commit has no effect.
- Reset mid-WAIT at PC=0x40 → outputs return to reset values immediately (asynchronously); after release, BOOT then fetch from RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and instruction fetch stage
//
// Purpose:
//   Holds the program counter, fetches the instruction at PC over a
//   request/response memory handshake and presents it to the single-cycle
//   datapath until the core commits it. On commit the next PC is chosen from
//   the branch-unit decision (PC+4, PC+imm or the JALR target). A misaligned
//   next PC parks the unit in an error state that only reset can leave.
//
// Parameters:
//   XLEN      datapath and address width
//   RESET_PC  PC loaded on reset; must be 4-byte aligned
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   PC_Src       in   1 = redirect to a target, 0 = PC+4
//   jalr         in   with PC_Src=1, take alu_result instead of PC+imm
//   imm          in   sign-extended branch/JAL offset
//   alu_result   in   JALR target from the ALU
//   commit       in   core finished executing instr this cycle
//   imem_req     out  fetch request valid
//   imem_addr    out  fetch address (always PC)
//   imem_ready   in   memory accepts the request this cycle
//   imem_rvalid  in   response data valid
//   imem_rdata   in   fetched instruction word
//   instr        out  registered instruction for decode
//   instr_valid  out  instr is valid and being executed
//   PC           out  address of the current instruction
//   PC_plus4     out  PC+4 for JAL/JALR link
//   misaligned   out  sticky fetch-target-misaligned error

module pc_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PC_Src,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            commit,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_plus4,
  output logic            misaligned
);

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            imem_req_q, imem_req_d;
  logic            misaligned_q, misaligned_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] next_pc;
  logic            next_pc_misaligned;

  // Next-PC candidates. Additions wrap modulo 2^XLEN.
  // The JALR target drops bit 0 as the ISA requires; bit 1 can still be set,
  // which is what makes a JALR target misaligned for a 4-byte fetch.
  always_comb begin
    pc_plus4           = pc_q + XLEN'(4);
    branch_target      = pc_q + imm;
    jalr_target        = alu_result & ~XLEN'(1);
    next_pc            = pc_plus4;
    if (PC_Src) begin
      next_pc = jalr ? jalr_target : branch_target;
    end
    next_pc_misaligned = |next_pc[1:0];
  end

  // Next-state and registered-output logic. Every output is a flop, so each
  // branch below sets the value the output should carry in the state being
  // entered, not the state being left.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    misaligned_d  = misaligned_q;

    unique case (state_q)
      S_BOOT: begin
        state_d    = S_REQ;
        imem_req_d = 1'b1;
      end

      S_REQ: begin
        // A response while the request is not yet accepted cannot belong to
        // this fetch, so imem_rvalid only matters together with imem_ready.
        if (imem_ready) begin
          imem_req_d = 1'b0;
          if (imem_rvalid) begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
      end

      S_HOLD: begin
        // Branch-unit inputs are only looked at here, on the commit cycle.
        if (commit) begin
          instr_valid_d = 1'b0;
          if (next_pc_misaligned) begin
            // PC keeps the address of the offending instruction.
            misaligned_d = 1'b1;
            state_d      = S_ERR;
          end else begin
            pc_d       = next_pc;
            imem_req_d = 1'b1;
            state_d    = S_REQ;
          end
        end
      end

      S_ERR: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
        misaligned_d  = 1'b1;
      end

      default: begin
        state_d       = S_BOOT;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign PC          = pc_q;
  assign PC_plus4    = pc_plus4;
  assign misaligned  = misaligned_q;

  // A fetch is never issued to an address that is not word aligned.
  a_req_aligned : assert property (
    @(posedge clk) disable iff (reset) imem_req_q |-> (imem_addr[1:0] == 2'b00)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard testbench for pc_fetch_unit

module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        PC_Src;
  logic        jalr;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        commit;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        misaligned;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .PC_Src     (PC_Src),
    .jalr       (jalr),
    .imm        (imm),
    .alu_result (alu_result),
    .commit     (commit),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .PC         (PC),
    .PC_plus4   (PC_plus4),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] m_pc;
  logic [31:0] exp_fetch_pc;

  // memory behaviour knobs
  int max_stall = 0;
  int max_lat   = 0;
  bit spur_en   = 0;
  bit ovr_en    = 0;
  int ovr_stall = 0;
  int ovr_lat   = 0;
  bit ovr_spur  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  initial begin
    #500000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  // ---------------- memory responder ----------------
  initial begin
    bit          pending;
    bit          in_req;
    bit          cur_spur;
    int          stall;
    int          lat;
    int          cnt;
    logic [31:0] paddr;
    pending = 0; in_req = 0; cur_spur = 0; stall = 0; lat = 0; cnt = 0; paddr = '0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (reset) begin
        pending = 0;
        in_req  = 0;
      end else if (pending) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pending     = 0;
        end else begin
          cnt--;
        end
      end else if (imem_req) begin
        if (!in_req) begin
          in_req = 1;
          if (ovr_en) begin
            stall = ovr_stall; lat = ovr_lat; cur_spur = ovr_spur; ovr_en = 0;
          end else begin
            stall    = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
            lat      = (max_lat > 0) ? int'($urandom_range(0, max_lat)) : 0;
            cur_spur = spur_en && ($urandom % 2 == 1);
          end
        end
        if (stall == 0) begin
          imem_ready = 1'b1;
          paddr      = imem_addr;
          in_req     = 0;
          if (lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(paddr);
          end else begin
            pending = 1;
            cnt     = lat - 1;
          end
        end else begin
          stall--;
          if (cur_spur) imem_rvalid = 1'b1;
        end
      end else if (spur_en && ($urandom % 4 == 0)) begin
        imem_rvalid = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t        e;
    bit          prev_v;
    bit          prev_m;
    bit          have_cur;
    logic [31:0] cur_pc;
    logic [31:0] cur_instr;
    logic [31:0] err_pc;
    prev_v = 0; prev_m = 0; have_cur = 0; cur_pc = '0; cur_instr = '0; err_pc = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v   = 0;
        prev_m   = 0;
        have_cur = 0;
      end else begin
        if (instr_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            have_cur = 0;
            $display("FAIL unexpected_instr: got pc %h instr %h required no new instruction", PC, instr);
          end else begin
            e = exp_q.pop_front();
            check("event_kind_instr", 32'(e.is_err), 32'd0);
            cur_pc    = e.pc;
            cur_instr = e.instr;
            have_cur  = 1;
          end
        end
        if (instr_valid && have_cur) begin
          check("hold_pc", PC, cur_pc);
          check("hold_instr", instr, cur_instr);
          check("hold_pc_plus4", PC_plus4, cur_pc + 32'd4);
        end
        if (misaligned && !prev_m) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_misaligned: got misaligned=1 at pc %h required 0", PC);
          end else begin
            e = exp_q.pop_front();
            check("event_kind_err", 32'(e.is_err), 32'd1);
            err_pc = e.pc;
          end
        end
        if (misaligned) begin
          check("err_pc_held", PC, err_pc);
          check("err_req_valid", {30'd0, imem_req, instr_valid}, 32'd0);
        end
        if (imem_req) check("fetch_addr", imem_addr, exp_fetch_pc);
        prev_v = instr_valid;
        prev_m = misaligned;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic randomize_branch_inputs();
    PC_Src     = 1'($urandom);
    jalr       = 1'($urandom);
    imm        = $urandom;
    alu_result = $urandom;
  endtask

  task automatic wait_hold(output int gap);
    gap = 0;
    @(negedge clk);
    while (!instr_valid) begin
      gap++;
      if (gap > 200) begin
        n_cmp++;
        n_fail++;
        $display("FAIL hold_timeout: got no instr_valid after %0d cycles required within 200", gap);
        finish_run();
      end
      // commit outside HOLD must be ignored
      commit = 1'($urandom);
      randomize_branch_inputs();
      @(negedge clk);
    end
    commit = 1'b0;
  endtask

  task automatic commit_now(input bit src, input bit j, input logic [31:0] imm_v,
                            input logic [31:0] alu_v, output bit err);
    logic [31:0] np;
    PC_Src     = src;
    jalr       = j;
    imm        = imm_v;
    alu_result = alu_v;
    commit     = 1'b1;
    if (!src)    np = m_pc + 32'd4;
    else if (!j) np = m_pc + imm_v;
    else         np = alu_v & 32'hFFFF_FFFE;
    if (np[1:0] != 2'b00) begin
      err = 1;
      exp_q.push_back('{1'b1, m_pc, 32'h0});
    end else begin
      err          = 0;
      m_pc         = np;
      exp_fetch_pc = np;
      exp_q.push_back('{1'b0, np, mem_word(np)});
    end
    @(posedge clk);
    #1;
    commit = 1'b0;
    randomize_branch_inputs();
  endtask

  task automatic step(input bit src, input bit j, input logic [31:0] imm_v,
                      input logic [31:0] alu_v, output int gap, output bit err);
    commit_now(src, j, imm_v, alu_v, err);
    gap = -1;
    if (!err) wait_hold(gap);
  endtask

  task automatic reset_assert();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_pc", PC, RST_PC);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_release();
    exp_q.delete();
    m_pc         = RST_PC;
    exp_fetch_pc = RST_PC;
    exp_q.push_back('{1'b0, RST_PC, mem_word(RST_PC)});
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("boot_req_low", 32'(imem_req), 32'd0);
  endtask

  initial begin
    int gap;
    bit err;
    reset = 1'b1;
    commit = 1'b0; PC_Src = 1'b0; jalr = 1'b0; imm = '0; alu_result = '0;
    m_pc = RST_PC; exp_fetch_pc = RST_PC;
    repeat (3) @(negedge clk);

    // boot with zero-wait memory
    check("rst_pc_init", PC, RST_PC);
    check("rst_valid_init", 32'(instr_valid), 32'd0);
    reset_release();
    @(negedge clk);
    check("boot_fetch_req", 32'(imem_req), 32'd1);
    check("boot_fetch_addr", imem_addr, 32'h0);
    wait_hold(gap);
    check("boot_latency", gap, 0);
    check("boot_instr", instr, 32'h0000_0013);
    check("boot_pc_plus4", PC_plus4, 32'h4);

    // sequential flow: 0x4, 0x8, 0xC with one-cycle bubbles
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, gap, err);
      check("seq_gap", gap, 1);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, gap, err);          // 0x10
    step(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, gap, err);  // 0x08
    check("branch_gap", gap, 1);
    step(1'b1, 1'b1, $urandom, 32'h0000_0101, gap, err); // 0x100
    check("jalr_pc", PC, 32'h0000_0100);

    // wait states: 3 stall cycles with spurious rvalid, response 2 after accept
    ovr_stall = 3; ovr_lat = 2; ovr_spur = 1; ovr_en = 1;
    step(1'b0, 1'b0, 32'h0, 32'h0, gap, err);          // 0x104
    check("wait_gap", gap, 6);

    // wrap-around to top of address space and back to 0
    step(1'b1, 1'b0, 32'hFFFF_FFFC - 32'h104, 32'h0, gap, err);
    step(1'b0, 1'b0, 32'h0, 32'h0, gap, err);
    check("wrap_pc", PC, 32'h0);

    // misaligned target
    step(1'b1, 1'b0, 32'h20, 32'h0, gap, err);         // 0x20
    step(1'b1, 1'b0, 32'h6, 32'h0, gap, err);
    check("misalign_expected", 32'(err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      commit = 1'b1; PC_Src = 1'b0;
    end
    @(negedge clk);
    commit = 1'b0;
    check("err_sticky", 32'(misaligned), 32'd1);
    check("err_pc", PC, 32'h20);
    check("err_req", 32'(imem_req), 32'd0);

    // reset out of ERR, then reset in the middle of WAIT at 0x40
    reset_assert();
    reset_release();
    wait_hold(gap);
    ovr_stall = 0; ovr_lat = 10; ovr_spur = 0; ovr_en = 1;
    commit_now(1'b1, 1'b0, 32'h40, 32'h0, err);
    @(negedge clk);
    check("midwait_req_addr", imem_addr, 32'h40);
    @(negedge clk);
    check("midwait_in_wait", {30'd0, imem_req, instr_valid}, 32'd0);
    reset_assert();
    reset_release();
    wait_hold(gap);
    check("reboot_pc", PC, RST_PC);

    // randomized traffic
    max_stall = 3; max_lat = 3; spur_en = 1;
    for (int i = 0; i < 150; i++) begin
      int          r;
      logic [31:0] iv;
      logic [31:0] av;
      r  = int'($urandom % 8);
      iv = 32'(int'($urandom_range(0, 64)) - 32) << 2;
      if ($urandom % 10 == 0) iv = iv + 32'd2;
      av = $urandom & 32'hFFFF_FFFC;
      if ($urandom % 8 == 0) av = $urandom;
      if (r < 4)      step(1'b0, 1'b0, $urandom, $urandom, gap, err);
      else if (r < 6) step(1'b1, 1'b0, iv, $urandom, gap, err);
      else            step(1'b1, 1'b1, $urandom, av, gap, err);
      if (err) begin
        repeat (2) @(negedge clk);
        check("rand_err_flag", 32'(misaligned), 32'd1);
        reset_assert();
        reset_release();
        wait_hold(gap);
      end
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    finish_run();
  end

endmodule
